// File: rtl/lut_arb_pkg.sv
// Shared types for the lookup-table port arbiter: RAM word field
// offsets, grant encodings and layout helpers.
package lut_arb_pkg;

    localparam int DEF_KEY_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH = 48;

    // RAM word = {valid, tag, data}, data in the low bits
    localparam int DATA_LSB  = 0;
    localparam int TAG_LSB   = DATA_LSB + DEF_DATA_WIDTH;
    localparam int VALID_POS = TAG_LSB + DEF_KEY_WIDTH;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_LK   = 2'd1,
        GNT_HOST = 2'd2
    } gnt_e;

    // Same layout for non-default widths
    function automatic int tag_lsb(input int dw);
        return DATA_LSB + dw;
    endfunction

    function automatic int valid_pos(input int kw, input int dw);
        return DATA_LSB + dw + kw;
    endfunction

endpackage

// File: rtl/lut_port_arbiter_if.sv
// Bus bundle for lut_port_arbiter: lookup, host and RAM signal groups.
// slave = arbiter side, master = lookup/host/RAM side.
interface lut_port_arbiter_if
    import lut_arb_pkg::*;
#(
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 5
);
    localparam int W = 1 + KEY_WIDTH + DATA_WIDTH;

    logic                  i_lk_valid;
    logic [KEY_WIDTH-1:0]  i_lk_key;
    logic                  o_lk_ready;
    logic                  o_lk_resp_valid;
    logic                  o_lk_found;
    logic [DATA_WIDTH-1:0] o_lk_data;

    logic                  i_host_req;
    logic                  i_host_wr;
    logic [ADDR_WIDTH-1:0] i_host_addr;
    logic [W-1:0]          i_host_wdata;
    logic                  o_host_ack;
    logic [W-1:0]          o_host_rdata;

    logic                  o_mem_en;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [W-1:0]          o_mem_wdata;
    logic [W-1:0]          i_mem_rdata;

    modport slave (
        input  i_lk_valid, i_lk_key,
        output o_lk_ready, o_lk_resp_valid, o_lk_found, o_lk_data,
        input  i_host_req, i_host_wr, i_host_addr, i_host_wdata,
        output o_host_ack, o_host_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_lk_valid, i_lk_key,
        input  o_lk_ready, o_lk_resp_valid, o_lk_found, o_lk_data,
        output i_host_req, i_host_wr, i_host_addr, i_host_wdata,
        input  o_host_ack, o_host_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );

endinterface

// File: rtl/lut_arb_inflight.sv
// Two-stage in-flight tracker for RAM accesses. Inputs: clk, reset,
// push_{kind,wr,key}. Outputs: s1 {kind,wr,key} aligned to RAM read data, s2 kind.
module lut_arb_inflight
    import lut_arb_pkg::*;
#(
    parameter int KEY_WIDTH = DEF_KEY_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  gnt_e                 push_kind,
    input  logic                 push_wr,
    input  logic [KEY_WIDTH-1:0] push_key,
    output gnt_e                 s1_kind,
    output logic                 s1_wr,
    output logic [KEY_WIDTH-1:0] s1_key,
    output gnt_e                 s2_kind
);

    gnt_e                 s1_kind_q, s1_kind_d;
    logic                 s1_wr_q, s1_wr_d;
    logic [KEY_WIDTH-1:0] s1_key_q, s1_key_d;
    gnt_e                 s2_kind_q, s2_kind_d;

    always_comb begin
        s1_kind_d = push_kind;
        s1_wr_d   = push_wr;
        s1_key_d  = push_key;
        s2_kind_d = s1_kind_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_kind_q <= GNT_IDLE;
            s1_wr_q   <= 1'b0;
            s1_key_q  <= '0;
            s2_kind_q <= GNT_IDLE;
        end else begin
            s1_kind_q <= s1_kind_d;
            s1_wr_q   <= s1_wr_d;
            s1_key_q  <= s1_key_d;
            s2_kind_q <= s2_kind_d;
        end
    end

    assign s1_kind = s1_kind_q;
    assign s1_wr   = s1_wr_q;
    assign s1_key  = s1_key_q;
    assign s2_kind = s2_kind_q;

endmodule

// File: rtl/lut_port_arbiter.sv
// Shares a single-port read-latency-1 lookup RAM between the lookup datapath
// and host register access; does the tag compare and returns found/data.
// Ports: clk, reset (sync, active-high), bus (lut_port_arbiter_if.slave).
// Optional macro HOST_STARVE_GUARD_EN: forces a host grant after MAX_WAIT
// waiting cycles; without it lookups have strict priority.
module lut_port_arbiter
    import lut_arb_pkg::*;
#(
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    lut_port_arbiter_if.slave bus
);

    localparam int W     = 1 + KEY_WIDTH + DATA_WIDTH;
    localparam int T_LSB = tag_lsb(DATA_WIDTH);
    localparam int V_POS = valid_pos(KEY_WIDTH, DATA_WIDTH);

    gnt_e                  gnt;
    logic                  force_host;
    logic                  pend_q, pend_d;

    gnt_e                  s1_kind, s2_kind;
    logic                  s1_wr;
    logic [KEY_WIDTH-1:0]  s1_key;

    logic                  hit;
    logic                  lk_found_q, lk_found_d;
    logic [DATA_WIDTH-1:0] lk_data_q, lk_data_d;
    logic [W-1:0]          host_rdata_q, host_rdata_d;

`ifdef HOST_STARVE_GUARD_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);

    logic [WCW-1:0] wait_q, wait_d;

    assign force_host = (wait_q == WCW'(MAX_WAIT))
                      && bus.i_host_req && !pend_q;

    always_comb begin
        wait_d = wait_q;
        if (gnt == GNT_HOST)
            wait_d = '0;
        else if (bus.i_host_req && !pend_q
                 && wait_q != WCW'(MAX_WAIT))
            wait_d = wait_q + WCW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) wait_q <= '0;
        else       wait_q <= wait_d;
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT > 0);
    assign force_host = 1'b0;
`endif

    // Nothing is granted while in reset so the RAM stays quiet
    always_comb begin
        gnt = GNT_IDLE;
        if (reset)
            gnt = GNT_IDLE;
        else if (force_host)
            gnt = GNT_HOST;
        else if (bus.i_lk_valid)
            gnt = GNT_LK;
        else if (bus.i_host_req && !pend_q)
            gnt = GNT_HOST;
    end

    always_comb begin
        bus.o_mem_en    = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        unique case (gnt)
            GNT_LK: begin
                bus.o_mem_en   = 1'b1;
                bus.o_mem_addr = bus.i_lk_key[ADDR_WIDTH-1:0];
            end
            GNT_HOST: begin
                bus.o_mem_en    = 1'b1;
                bus.o_mem_we    = bus.i_host_wr;
                bus.o_mem_addr  = bus.i_host_addr;
                bus.o_mem_wdata = bus.i_host_wr ? bus.i_host_wdata : '0;
            end
            default: ;
        endcase
    end

    assign bus.o_lk_ready = (gnt != GNT_HOST);

    lut_arb_inflight #(
        .KEY_WIDTH (KEY_WIDTH)
    ) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .push_kind (gnt),
        .push_wr   ((gnt == GNT_HOST) && bus.i_host_wr),
        .push_key  (bus.i_lk_key),
        .s1_kind   (s1_kind),
        .s1_wr     (s1_wr),
        .s1_key    (s1_key),
        .s2_kind   (s2_kind)
    );

    // Pending covers grant through ack so a held request is not re-run
    always_comb begin
        pend_d = pend_q;
        if (gnt == GNT_HOST)
            pend_d = 1'b1;
        else if (s2_kind == GNT_HOST)
            pend_d = 1'b0;
    end

    // RAM read data lines up with s1; results are zero outside a response
    always_comb begin
        hit = bus.i_mem_rdata[V_POS]
            && (bus.i_mem_rdata[T_LSB +: KEY_WIDTH] == s1_key);
        lk_found_d   = (s1_kind == GNT_LK) && hit;
        lk_data_d    = lk_found_d ?
                       bus.i_mem_rdata[DATA_LSB +: DATA_WIDTH] : '0;
        host_rdata_d = (s1_kind == GNT_HOST && !s1_wr) ?
                       bus.i_mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q       <= 1'b0;
            lk_found_q   <= 1'b0;
            lk_data_q    <= '0;
            host_rdata_q <= '0;
        end else begin
            pend_q       <= pend_d;
            lk_found_q   <= lk_found_d;
            lk_data_q    <= lk_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bus.o_lk_resp_valid = (s2_kind == GNT_LK);
    assign bus.o_lk_found      = lk_found_q;
    assign bus.o_lk_data       = lk_data_q;
    assign bus.o_host_ack      = (s2_kind == GNT_HOST);
    assign bus.o_host_rdata    = host_rdata_q;

endmodule
